// File: rtl/instr_decode_if.sv
// instr_decode_if
//   Bundles the instruction-decode pipe handshake and data buses.
//   Upstream side : in_valid, in_ready, in_ins, in_pc, flush
//   Downstream side: out_valid, out_ready, out_opcode/rd/funct3/rs1/rs2/funct7,
//                    out_imm, out_fmt, out_illegal, out_pc, dec_count
//   slave  modport : the decode pipe itself
//   master modport : whoever drives instructions in and consumes bundles
interface instr_decode_if #(
    parameter int XLEN  = 32,
    parameter int PC_W  = 32,
    parameter int CNT_W = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_ins;
    logic [PC_W-1:0]   in_pc;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [6:0]        out_opcode;
    logic [4:0]        out_rd;
    logic [2:0]        out_funct3;
    logic [4:0]        out_rs1;
    logic [4:0]        out_rs2;
    logic [6:0]        out_funct7;
    logic [XLEN-1:0]   out_imm;
    logic [2:0]        out_fmt;
    logic              out_illegal;
    logic [PC_W-1:0]   out_pc;
    logic [CNT_W-1:0]  dec_count;

    modport slave (
        input  in_valid, in_ins, in_pc, flush, out_ready,
        output in_ready, out_valid, out_opcode, out_rd, out_funct3, out_rs1,
               out_rs2, out_funct7, out_imm, out_fmt, out_illegal, out_pc,
               dec_count
    );

    modport master (
        output in_valid, in_ins, in_pc, flush, out_ready,
        input  in_ready, out_valid, out_opcode, out_rd, out_funct3, out_rs1,
               out_rs2, out_funct7, out_imm, out_fmt, out_illegal, out_pc,
               dec_count
    );
endinterface

// File: rtl/instr_decode_pipe.sv
// instr_decode_pipe
//   Decodes a 32-bit RISC-V style instruction word into its fields, format
//   and sign-extended immediate, and registers the result behind a
//   valid/ready handshake with a one-entry skid buffer (two bundles max).
//   Ports:
//     clk  - clock, rising edge
//     rst  - asynchronous, active-high reset
//     bus  - instr_decode_if.slave: input handshake + instruction/PC,
//            flush, output handshake + decoded bundle, dec_count
module instr_decode_pipe #(
    parameter int XLEN  = 32,
    parameter int PC_W  = 32,
    parameter int CNT_W = 16
) (
    input  logic          clk,
    input  logic          rst,
    instr_decode_if.slave bus
);
    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_ILL = 3'd7;

    typedef struct packed {
        logic [6:0]      opcode;
        logic [4:0]      rd;
        logic [2:0]      funct3;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [6:0]      funct7;
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            illegal;
        logic [PC_W-1:0] pc;
    } bundle_t;

    function automatic bundle_t decode(input logic [31:0] ins, input logic [PC_W-1:0] pc);
        bundle_t            b;
        logic [2:0]         fmt;
        logic signed [31:0] imm32;
        b.opcode = ins[6:0];
        b.rd     = ins[11:7];
        b.funct3 = ins[14:12];
        b.rs1    = ins[19:15];
        b.rs2    = ins[24:20];
        b.funct7 = ins[31:25];
        b.pc     = pc;
        case (ins[6:0])
            7'b0110011:                                     fmt = FMT_R;
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: fmt = FMT_I;
            7'b0100011:                                     fmt = FMT_S;
            7'b1100011:                                     fmt = FMT_B;
            7'b0110111, 7'b0010111:                         fmt = FMT_U;
            7'b1101111:                                     fmt = FMT_J;
            default:                                        fmt = FMT_ILL;
        endcase
        // Compressed/non-32-bit encodings are rejected even if bits [6:2] match.
        if (ins[1:0] != 2'b11) fmt = FMT_ILL;
        case (fmt)
            FMT_I:   imm32 = {{20{ins[31]}}, ins[31:20]};
            FMT_S:   imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            FMT_B:   imm32 = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
            FMT_U:   imm32 = {ins[31:12], 12'b0};
            FMT_J:   imm32 = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
            default: imm32 = '0;
        endcase
        // Size cast of a signed value sign-extends to XLEN.
        b.imm     = XLEN'(imm32);
        b.fmt     = fmt;
        b.illegal = (fmt == FMT_ILL);
        return b;
    endfunction

    // Stage p0: combinational decode of the incoming word
    bundle_t dec_p0;
    logic    take_in;
    logic    take_out;

    // Stage p1: output register plus skid register
    bundle_t          out_p1;
    bundle_t          skid_p1;
    logic             vld_p1;
    logic             skid_vld_p1;
    logic [CNT_W-1:0] cnt;

    assign dec_p0   = decode(bus.in_ins, bus.in_pc);
    // in_ready comes straight from the skid flag, so there is no
    // combinational path from out_ready back to in_ready.
    assign take_in  = bus.in_valid && !skid_vld_p1 && !bus.flush;
    assign take_out = vld_p1 && bus.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1      <= 1'b0;
            skid_vld_p1 <= 1'b0;
            out_p1      <= '0;
            skid_p1     <= '0;
            cnt         <= '0;
        end else if (bus.flush) begin
            // A bundle presented during flush is discarded, so it is not counted.
            vld_p1      <= 1'b0;
            skid_vld_p1 <= 1'b0;
        end else begin
            if (take_out) cnt <= cnt + 1'b1;
            if (take_out && skid_vld_p1) begin
                out_p1      <= skid_p1;
                skid_vld_p1 <= 1'b0;
            end else if (take_in && (!vld_p1 || take_out)) begin
                out_p1 <= dec_p0;
                vld_p1 <= 1'b1;
            end else if (take_in) begin
                skid_p1     <= dec_p0;
                skid_vld_p1 <= 1'b1;
            end else if (take_out) begin
                vld_p1 <= 1'b0;
            end
        end
    end

    assign bus.in_ready    = !skid_vld_p1;
    assign bus.out_valid   = vld_p1;
    assign bus.out_opcode  = out_p1.opcode;
    assign bus.out_rd      = out_p1.rd;
    assign bus.out_funct3  = out_p1.funct3;
    assign bus.out_rs1     = out_p1.rs1;
    assign bus.out_rs2     = out_p1.rs2;
    assign bus.out_funct7  = out_p1.funct7;
    assign bus.out_imm     = out_p1.imm;
    assign bus.out_fmt     = out_p1.fmt;
    assign bus.out_illegal = out_p1.illegal;
    assign bus.out_pc      = out_p1.pc;
    assign bus.dec_count   = cnt;
endmodule

// File: tb/tb_instr_decode_pipe.sv
// tb_instr_decode_pipe
//   Drives instr_decode_pipe (XLEN=32, plus an XLEN=64 twin fed the same
//   stimulus) with directed and random instructions and compares every
//   cycle against a queue-based reference model.
module tb_instr_decode_pipe;
    localparam int PC_W  = 32;
    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    instr_decode_if #(.XLEN(32), .PC_W(PC_W), .CNT_W(CNT_W)) bus32 ();
    instr_decode_if #(.XLEN(64), .PC_W(PC_W), .CNT_W(CNT_W)) bus64 ();

    instr_decode_pipe #(.XLEN(32), .PC_W(PC_W), .CNT_W(CNT_W)) dut32 (
        .clk(clk), .rst(rst), .bus(bus32)
    );
    instr_decode_pipe #(.XLEN(64), .PC_W(PC_W), .CNT_W(CNT_W)) dut64 (
        .clk(clk), .rst(rst), .bus(bus64)
    );

    assign bus64.in_valid  = bus32.in_valid;
    assign bus64.in_ins    = bus32.in_ins;
    assign bus64.in_pc     = bus32.in_pc;
    assign bus64.flush     = bus32.flush;
    assign bus64.out_ready = bus32.out_ready;

    typedef struct {
        logic [31:0] ins;
        logic [31:0] pc;
    } item_t;

    item_t            q[$];
    logic [CNT_W-1:0] cnt_m = '0;
    int               checks = 0;
    int               failures = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Immediate computed as a signed integer from the field values.
    function automatic void ref_decode(input logic [31:0] ins, output int fmt, output longint imm);
        case (ins[6:0])
            7'b0110011:                                     fmt = 0;
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: fmt = 1;
            7'b0100011:                                     fmt = 2;
            7'b1100011:                                     fmt = 3;
            7'b0110111, 7'b0010111:                         fmt = 4;
            7'b1101111:                                     fmt = 5;
            default:                                        fmt = 7;
        endcase
        if (ins[1:0] != 2'b11) fmt = 7;
        imm = 0;
        case (fmt)
            1: begin
                imm = longint'(ins[31:20]);
                if (imm >= 2048) imm -= 4096;
            end
            2: begin
                imm = longint'(ins[31:25]) * 32 + longint'(ins[11:7]);
                if (imm >= 2048) imm -= 4096;
            end
            3: begin
                imm = longint'(ins[31]) * 4096 + longint'(ins[7]) * 2048
                    + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2;
                if (imm >= 4096) imm -= 8192;
            end
            4: begin
                imm = longint'(ins[31:12]) * 4096;
                if (imm >= 64'sh8000_0000) imm -= 64'sh1_0000_0000;
            end
            5: begin
                imm = longint'(ins[31]) * 1048576 + longint'(ins[19:12]) * 4096
                    + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2;
                if (imm >= 1048576) imm -= 2097152;
            end
            default: imm = 0;
        endcase
    endfunction

    task automatic model_edge();
        bit in_rdy;
        bit out_vld;
        in_rdy  = (q.size() < 2);
        out_vld = (q.size() > 0);
        if (rst) begin
            q.delete();
            cnt_m = '0;
            return;
        end
        if (bus32.flush) begin
            q.delete();
            return;
        end
        if (out_vld && bus32.out_ready) begin
            void'(q.pop_front());
            cnt_m = cnt_m + 1'b1;
        end
        if (bus32.in_valid && in_rdy) q.push_back('{ins: bus32.in_ins, pc: bus32.in_pc});
    endtask

    task automatic check_state();
        int          fmt;
        longint      imm;
        logic [63:0] e64;
        check("in_ready", 64'(bus32.in_ready), 64'(q.size() < 2));
        check("out_valid", 64'(bus32.out_valid), 64'(q.size() > 0));
        check("dec_count", 64'(bus32.dec_count), 64'(cnt_m));
        if (q.size() > 0) begin
            ref_decode(q[0].ins, fmt, imm);
            e64 = imm;
            check("fields", 64'({bus32.out_funct7, bus32.out_rs2, bus32.out_rs1,
                                 bus32.out_funct3, bus32.out_rd, bus32.out_opcode}), 64'(q[0].ins));
            check("fmt", 64'(bus32.out_fmt), 64'(fmt));
            check("illegal", 64'(bus32.out_illegal), 64'(fmt == 7));
            check("imm32", 64'(bus32.out_imm), {32'b0, e64[31:0]});
            check("imm64", bus64.out_imm, e64);
            check("pc", 64'(bus32.out_pc), 64'(q[0].pc));
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_state();
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                         input logic ordy, input logic fl);
        bus32.in_valid  = v;
        bus32.in_ins    = ins;
        bus32.in_pc     = pc;
        bus32.out_ready = ordy;
        bus32.flush     = fl;
    endtask

    logic [6:0]       ops [12] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111,
                                   7'b1110011, 7'b0100011, 7'b1100011, 7'b0110111,
                                   7'b0010111, 7'b1101111, 7'b1111111, 7'b0110010};
    logic [CNT_W-1:0] saved_cnt;
    logic [31:0]      r;

    initial begin
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #2 rst = 1'b1;
        model_edge();
        @(negedge clk);
        @(negedge clk);
        // Reset state
        check("rst_out_valid", 64'(bus32.out_valid), 64'd0);
        check("rst_in_ready", 64'(bus32.in_ready), 64'd1);
        check("rst_dec_count", 64'(bus32.dec_count), 64'd0);
        check("rst_fields", 64'({bus32.out_funct7, bus32.out_rs2, bus32.out_rs1,
                                 bus32.out_funct3, bus32.out_rd, bus32.out_opcode}), 64'd0);
        check("rst_imm", 64'(bus32.out_imm), 64'd0);
        check("rst_fmt_ill_pc", 64'({bus32.out_fmt, bus32.out_illegal, bus32.out_pc}), 64'd0);
        rst = 1'b0;

        // addi x1,x0,5
        drive(1'b1, 32'h0050_0093, 32'h100, 1'b1, 1'b0);
        cycle();
        check("addi_fmt", 64'(bus32.out_fmt), 64'd1);
        check("addi_rd", 64'(bus32.out_rd), 64'd1);
        check("addi_imm", 64'(bus32.out_imm), 64'd5);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        cycle();
        check("addi_cnt", 64'(bus32.dec_count), 64'd1);

        // beq, offset -4
        drive(1'b1, 32'hFE00_0EE3, 32'h104, 1'b1, 1'b0);
        cycle();
        check("beq_fmt", 64'(bus32.out_fmt), 64'd3);
        check("beq_imm32", 64'(bus32.out_imm), 64'hFFFF_FFFC);
        check("beq_imm64", bus64.out_imm, 64'hFFFF_FFFF_FFFF_FFFC);

        // Illegal encodings
        drive(1'b1, 32'h0000_007F, 32'h108, 1'b1, 1'b0);
        cycle();
        check("ill7f", 64'({bus32.out_illegal, bus32.out_fmt}), 64'({1'b1, 3'd7}));
        check("ill7f_imm", 64'(bus32.out_imm), 64'd0);
        drive(1'b1, 32'h0000_0000, 32'h10C, 1'b1, 1'b0);
        cycle();
        check("ill00", 64'({bus32.out_illegal, bus32.out_fmt}), 64'({1'b1, 3'd7}));
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        cycle();
        cycle();

        // Backpressure: A then B held, then drained in order
        drive(1'b1, 32'h0010_0113, 32'hA0, 1'b0, 1'b0);
        cycle();
        drive(1'b1, 32'h0020_0193, 32'hB0, 1'b0, 1'b0);
        cycle();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        cycle();
        check("bp_in_ready", 64'(bus32.in_ready), 64'd0);
        check("bp_head_a", 64'(bus32.out_pc), 64'hA0);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        cycle();
        check("bp_head_b", 64'(bus32.out_pc), 64'hB0);
        check("bp_in_ready_up", 64'(bus32.in_ready), 64'd1);
        cycle();

        // Flush with two held and an input offered
        drive(1'b1, 32'h0030_0213, 32'hC0, 1'b0, 1'b0);
        cycle();
        drive(1'b1, 32'h0040_0293, 32'hC4, 1'b0, 1'b0);
        cycle();
        saved_cnt = cnt_m;
        drive(1'b1, 32'h0050_0313, 32'hC8, 1'b0, 1'b1);
        cycle();
        check("flush_out_valid", 64'(bus32.out_valid), 64'd0);
        check("flush_in_ready", 64'(bus32.in_ready), 64'd1);
        check("flush_cnt", 64'(bus32.dec_count), 64'(saved_cnt));
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        cycle();
        check("flush_dropped", 64'(bus32.out_valid), 64'd0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            r = $urandom();
            drive(($urandom() % 4) != 0, {r[31:7], ops[$urandom() % 12]}, $urandom(),
                  ($urandom() % 3) != 0, ($urandom() % 32) == 0);
            cycle();
        end

        // Reset in the middle of traffic
        drive(1'b1, 32'h0060_0393, 32'hD0, 1'b0, 1'b0);
        cycle();
        @(negedge clk);
        rst = 1'b1;
        #1;
        q.delete();
        cnt_m = '0;
        check("mrst_out_valid", 64'(bus32.out_valid), 64'd0);
        check("mrst_cnt", 64'(bus32.dec_count), 64'd0);
        check("mrst_in_ready", 64'(bus32.in_ready), 64'd1);
        cycle();
        rst = 1'b0;

        // 17 transfers wrap a 4-bit counter to 1
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 32'h0000_0013 | (i << 20), 32'h200 + i * 4, 1'b1, 1'b0);
            cycle();
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        cycle();
        check("wrap_cnt", 64'(bus32.dec_count), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
